mfp_avalon_sram_responder: RTL and testbench



---
 rtl/mfp_avalon_sram_responder.sv | 203 ++++++++++++++++++++
 tb/tb_mfp_avalon_sram_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_avalon_sram_responder.sv
// Avalon-MM responder backed by on-chip RAM, a drop-in for the external memory wrapper.
// Serves single/burst reads and byte-enabled writes with fixed read latency and optional write stalls.
module mfp_avalon_sram_responder #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned WRITE_WAIT   = 0
) (
    input  logic        SI_ClkIn,
    input  logic        SI_Reset,
    input  logic [31:0] avm_address,
    input  logic        avm_read,
    input  logic        avm_write,
    input  logic [3:0]  avm_byteenable,
    input  logic [2:0]  avm_burstcount,
    input  logic        avm_beginbursttransfer,
    input  logic        avm_begintransfer,
    input  logic [31:0] avm_writedata,
    output logic        avm_waitrequest,
    output logic        avm_readdatavalid,
    output logic [31:0] avm_readdata
);

    typedef enum logic [1:0] {
        StIdle,
        StWrWait,
        StWrBurst,
        StRdBurst
    } state_e;

    localparam logic [1:0] WAIT_MAX = 2'(WRITE_WAIT);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              left_q, left_d;
    logic [1:0]              wait_q, wait_d;
    logic                    first_q, first_d;

    logic [31:0]             ram [2**ADDR_WIDTH];
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic                    rd_en;
    logic                    rd_last;

    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] last_q;
    logic [31:0]             data_q [READ_LATENCY];

    logic [ADDR_WIDTH-1:0]   bus_addr;
    logic [2:0]              bus_count;
    logic                    wait_done;
    logic                    out_done;

    assign bus_addr  = avm_address[ADDR_WIDTH+1:2];
    assign bus_count = (avm_burstcount == 3'd0) ? 3'd1 : avm_burstcount;
    assign wait_done = (wait_q == WAIT_MAX);
    assign out_done  = vld_q[READ_LATENCY-1] & last_q[READ_LATENCY-1];

    // Upper/lower address bits and the transfer markers carry no information here.
    logic unused_ok;
    assign unused_ok = ^{avm_address[31:ADDR_WIDTH+2], avm_address[1:0],
                         avm_beginbursttransfer, avm_begintransfer};

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        left_d          = left_q;
        wait_d          = wait_q;
        first_d         = first_q;
        avm_waitrequest = 1'b1;
        ram_we          = 1'b0;
        ram_waddr       = bus_addr;
        rd_en           = 1'b0;
        rd_last         = 1'b0;

        if (!SI_Reset) begin
            unique case (state_q)
                StIdle: begin
                    avm_waitrequest = avm_write && (WRITE_WAIT != 0);
                    // Write wins over a simultaneous read.
                    if (avm_write) begin
                        if (WRITE_WAIT == 0) begin
                            ram_we    = 1'b1;
                            ram_waddr = bus_addr;
                            addr_d    = bus_addr + ADDR_WIDTH'(1);
                            left_d    = bus_count - 3'd1;
                            if (bus_count != 3'd1) begin
                                state_d = StWrBurst;
                            end
                        end else begin
                            // This cycle already counts as the first stall cycle.
                            state_d = StWrWait;
                            wait_d  = 2'd1;
                            first_d = 1'b1;
                        end
                    end else if (avm_read) begin
                        addr_d  = bus_addr;
                        left_d  = bus_count;
                        state_d = StRdBurst;
                    end
                end

                StWrWait: begin
                    avm_waitrequest = !avm_write || !wait_done;
                    if (!wait_done) begin
                        wait_d = wait_q + 2'd1;
                    end else if (avm_write) begin
                        ram_we    = 1'b1;
                        ram_waddr = first_q ? bus_addr : addr_q;
                        addr_d    = ram_waddr + ADDR_WIDTH'(1);
                        left_d    = (first_q ? bus_count : left_q) - 3'd1;
                        first_d   = 1'b0;
                        wait_d    = 2'd0;
                        if (left_d == 3'd0) begin
                            state_d = StIdle;
                        end
                    end
                end

                StWrBurst: begin
                    avm_waitrequest = !avm_write;
                    if (avm_write) begin
                        ram_we    = 1'b1;
                        ram_waddr = addr_q;
                        addr_d    = addr_q + ADDR_WIDTH'(1);
                        left_d    = left_q - 3'd1;
                        if (left_q == 3'd1) begin
                            state_d = StIdle;
                        end
                    end
                end

                StRdBurst: begin
                    avm_waitrequest = 1'b1;
                    if (left_q != 3'd0) begin
                        rd_en   = 1'b1;
                        rd_last = (left_q == 3'd1);
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        left_d  = left_q - 3'd1;
                    end
                    if (out_done) begin
                        state_d = StIdle;
                    end
                end

                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            left_q  <= '0;
            wait_q  <= '0;
            first_q <= 1'b0;
            vld_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            wait_q    <= wait_d;
            first_q   <= first_d;
            vld_q[0]  <= rd_en;
            last_q[0] <= rd_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    // Stage 0 is the RAM output register; later stages pad out the read latency.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            if (rd_en) begin
                data_q[0] <= ram[addr_q];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    always_ff @(posedge SI_ClkIn) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (avm_byteenable[b]) begin
                    ram[ram_waddr][8*b +: 8] <= avm_writedata[8*b +: 8];
                end
            end
        end
    end

    assign avm_readdatavalid = vld_q[READ_LATENCY-1];
    assign avm_readdata      = data_q[READ_LATENCY-1];

endmodule

// File: tb/tb_mfp_avalon_sram_responder.sv
// Scoreboard bench for mfp_avalon_sram_responder: two instances (no stall / write stall),
// a word-array memory model and per-instance expected-beat queues checked by a monitor.
module tb_mfp_avalon_sram_responder;

    localparam int unsigned AW    = 4;
    localparam int          WORDS = 16;
    localparam int unsigned RL0   = 2;
    localparam int unsigned WW0   = 0;
    localparam int unsigned RL1   = 3;
    localparam int unsigned WW1   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst     [2];
    logic [31:0] address [2];
    logic        cmd_rd  [2];
    logic        cmd_wr  [2];
    logic [3:0]  be      [2];
    logic [2:0]  bc      [2];
    logic        bbt     [2];
    logic        bt      [2];
    logic [31:0] wdata   [2];
    logic        wreq    [2];
    logic        rdv     [2];
    logic [31:0] rdata   [2];

    mfp_avalon_sram_responder #(
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL0),
        .WRITE_WAIT  (WW0)
    ) dut0 (
        .SI_ClkIn              (clk),
        .SI_Reset              (rst[0]),
        .avm_address           (address[0]),
        .avm_read              (cmd_rd[0]),
        .avm_write             (cmd_wr[0]),
        .avm_byteenable        (be[0]),
        .avm_burstcount        (bc[0]),
        .avm_beginbursttransfer(bbt[0]),
        .avm_begintransfer     (bt[0]),
        .avm_writedata         (wdata[0]),
        .avm_waitrequest       (wreq[0]),
        .avm_readdatavalid     (rdv[0]),
        .avm_readdata          (rdata[0])
    );

    mfp_avalon_sram_responder #(
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL1),
        .WRITE_WAIT  (WW1)
    ) dut1 (
        .SI_ClkIn              (clk),
        .SI_Reset              (rst[1]),
        .avm_address           (address[1]),
        .avm_read              (cmd_rd[1]),
        .avm_write             (cmd_wr[1]),
        .avm_byteenable        (be[1]),
        .avm_burstcount        (bc[1]),
        .avm_beginbursttransfer(bbt[1]),
        .avm_begintransfer     (bt[1]),
        .avm_writedata         (wdata[1]),
        .avm_waitrequest       (wreq[1]),
        .avm_readdatavalid     (rdv[1]),
        .avm_readdata          (rdata[1])
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] mem  [2][WORDS];
    logic [31:0] wbuf [8];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int d, input logic [31:0] data, input int c);
        exp_t e;
        e.data = data;
        e.cyc  = 32'(c);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon_beat(input int d);
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rdv dut%0d: got readdatavalid data %h at cycle %0d, expected none",
                     d, rdata[d], cyc);
        end else begin
            if (d == 0) e = q0.pop_front();
            else e = q1.pop_front();
            check($sformatf("rdata dut%0d", d), rdata[d], e.data);
            check($sformatf("rdv_cycle dut%0d", d), 32'(cyc), e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rdv[0]) mon_beat(0);
        if (rdv[1]) mon_beat(1);
    end

    task automatic drive_cmd(input int d, input int word, input logic r, input logic w,
                             input logic [2:0] bcv, input logic [3:0] bev,
                             input logic [31:0] data, input logic first);
        logic [31:0] a;
        a      = $urandom;
        a[5:2] = 4'(word);
        address[d] = a;
        cmd_rd[d]  = r;
        cmd_wr[d]  = w;
        bc[d]      = bcv;
        be[d]      = bev;
        wdata[d]   = data;
        bbt[d]     = first;
        bt[d]      = r | w;
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(negedge clk);
            drive_cmd(d, 0, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0, 1'b0);
        end
    endtask

    task automatic write_burst(input int d, input int word, input int bcv, input logic [3:0] bev,
                               input bit also_read, input bit gap_read);
        int n, ww, waits;
        bit acc, gapped;
        n  = (bcv == 0) ? 1 : bcv;
        ww = (d == 0) ? WW0 : WW1;
        for (int b = 0; b < n; b++) begin
            gapped = 0;
            if (gap_read && b == 1) begin
                @(negedge clk);
                drive_cmd(d, $urandom_range(0, 15), 1'b1, 1'b0, 3'(bcv), bev, $urandom, 1'b0);
                #1;
                check($sformatf("wreq_read_held_off dut%0d", d), wreq[d], 1);
                gapped = 1;
            end
            acc   = 0;
            waits = 0;
            while (!acc && waits < 16) begin
                @(negedge clk);
                drive_cmd(d, (b == 0) ? word : $urandom_range(0, 15), also_read, 1'b1,
                          3'(bcv), bev, wbuf[b], b == 0);
                #1;
                if (!wreq[d]) acc = 1;
                else waits++;
            end
            if (!acc) begin
                check($sformatf("write_accept_timeout dut%0d", d), 0, 1);
                return;
            end
            for (int l = 0; l < 4; l++) begin
                if (bev[l]) mem[d][(word + b) % WORDS][8*l +: 8] = wbuf[b][8*l +: 8];
            end
            if (gapped) check($sformatf("write_waits_after_gap dut%0d", d), waits <= ww, 1);
            else check($sformatf("write_waits dut%0d", d), waits, ww);
            @(posedge clk);
        end
    endtask

    task automatic read_burst(input int d, input int word, input int bcv, input int abort_beat);
        int n, rl, waits, t;
        bit acc;
        n     = (bcv == 0) ? 1 : bcv;
        rl    = (d == 0) ? RL0 : RL1;
        acc   = 0;
        waits = 0;
        while (!acc && waits < 16) begin
            @(negedge clk);
            drive_cmd(d, word, 1'b1, 1'b0, 3'(bcv), 4'($urandom), $urandom, 1'b1);
            #1;
            if (!wreq[d]) acc = 1;
            else waits++;
        end
        if (!acc) begin
            check($sformatf("read_accept_timeout dut%0d", d), 0, 1);
            return;
        end
        check($sformatf("read_waits dut%0d", d), waits, 0);
        t = cyc + 1;
        for (int i = 0; i < n; i++) push_exp(d, mem[d][(word + i) % WORDS], t + rl + i);
        while (1) begin
            @(negedge clk);
            drive_cmd(d, 0, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0, 1'b0);
            #1;
            if (abort_beat >= 0 && cyc == t + rl + abort_beat) begin
                rst[d] = 1'b1;
                if (d == 0) q0.delete();
                else q1.delete();
                #1;
                check($sformatf("wreq_in_reset dut%0d", d), wreq[d], 1);
                repeat (2) begin
                    @(negedge clk);
                    #1;
                    check($sformatf("wreq_in_reset dut%0d", d), wreq[d], 1);
                    check($sformatf("rdv_in_reset dut%0d", d), rdv[d], 0);
                end
                @(negedge clk);
                rst[d] = 1'b0;
                #1;
                check($sformatf("wreq_after_reset dut%0d", d), wreq[d], 0);
                return;
            end
            check($sformatf("read_wreq dut%0d", d), wreq[d], (cyc < t + rl + n) ? 1 : 0);
            if (cyc >= t + rl + n) break;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            drive_cmd(d, 0, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0, 1'b0);
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_wreq dut%0d", d), wreq[d], 1);
            check($sformatf("reset_rdv dut%0d", d), rdv[d], 0);
            check($sformatf("reset_rdata dut%0d", d), rdata[d], 0);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check($sformatf("release_wreq dut%0d", d), wreq[d], 0);

        for (int d = 0; d < 2; d++) begin
            // Fill every word so later reads have a defined model value.
            for (int k = 0; k < 3; k++) begin
                for (int b = 0; b < 8; b++) wbuf[b] = $urandom;
                write_burst(d, k * 7, (k == 2) ? 2 : 7, 4'hF, 0, 0);
            end

            wbuf[0] = 32'hDEADBEEF;
            write_burst(d, 4, 1, 4'hF, 0, 0);
            read_burst(d, 4, 1, -1);

            wbuf[0] = 32'h11223344;
            write_burst(d, 5, 1, 4'hF, 0, 0);
            wbuf[0] = 32'hAABBCCDD;
            write_burst(d, 5, 1, 4'b0101, 0, 0);
            read_burst(d, 5, 1, -1);
            wbuf[0] = $urandom;
            write_burst(d, 5, 1, 4'b0000, 0, 0);
            read_burst(d, 5, 1, -1);

            for (int b = 0; b < 4; b++) wbuf[b] = 32'(b + 1);
            write_burst(d, 14, 4, 4'hF, 0, 0);
            read_burst(d, 14, 4, -1);
            read_burst(d, 0, 2, -1);

            for (int b = 0; b < 3; b++) wbuf[b] = $urandom;
            write_burst(d, 9, 3, 4'hF, 0, 1);
            read_burst(d, 8, 5, -1);

            read_burst(d, 14, 4, 1);
            read_burst(d, 14, 4, -1);

            wbuf[0] = $urandom;
            write_burst(d, 3, 0, 4'hF, 0, 0);
            read_burst(d, 2, 3, -1);
            read_burst(d, 3, 0, -1);

            wbuf[0] = $urandom;
            write_burst(d, 7, 1, 4'hF, 1, 0);
            idle(d, 6);
            read_burst(d, 6, 3, -1);

            repeat (25) begin
                int word, bcv;
                word = $urandom_range(0, 15);
                bcv  = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) begin
                    for (int b = 0; b < 8; b++) wbuf[b] = $urandom;
                    write_burst(d, word, bcv, 4'($urandom), $urandom_range(0, 3) == 0, 0);
                end else begin
                    read_burst(d, word, bcv, -1);
                end
            end
            idle(d, 2);
        end

        idle(0, 8);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
